// File: rtl/led_snake_monitor.sv
// led_snake_monitor
//   Receive-side checker for the one-hot bouncing LED pattern. The LED bank is
//   registered once (pat_q), compared with the previous distinct pattern
//   (pat_prev) to detect movement events, and each event is classified as an
//   acquisition, a legal step, a legal end-of-bar bounce, or an error.
//
// Ports
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   led_array_i   LED pattern under observation
//   clr_i         synchronous clear of err_o, err_code_o, bounce_cnt_o
//   index_o       bit number of the lit LED
//   valid_o       tracked pattern is one-hot
//   dir_o         1 = moving toward MSB, 0 = toward LSB
//   step_o        one-cycle pulse per legal move
//   bounce_cnt_o  saturating count of legal reversals
//   err_o         sticky error flag
//   err_code_o    first error: 00 none, 01 bad pattern, 10 jump, 11 mid-bar reversal
//   state_o       FSM state (0 = IDLE, 1 = TRACK), for observation only
//
// Handshake: there is none. led_array_i is sampled every cycle with no
// valid/ready; a movement event is any cycle where the registered pattern
// differs from the previous one, and every output is registered.
module led_snake_monitor #(
  parameter  int NO_LEDS = 8,
  parameter  int CNT_W   = 8,
  localparam int IDX_W   = $clog2(NO_LEDS)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NO_LEDS-1:0] led_array_i,
  input  logic               clr_i,
  output logic [IDX_W-1:0]   index_o,
  output logic               valid_o,
  output logic               dir_o,
  output logic               step_o,
  output logic [CNT_W-1:0]   bounce_cnt_o,
  output logic               err_o,
  output logic [1:0]         err_code_o,
  output logic               state_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_e;

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NO_LEDS - 1);
  localparam logic [1:0] ERR_BAD  = 2'b01;
  localparam logic [1:0] ERR_JUMP = 2'b10;
  localparam logic [1:0] ERR_REV  = 2'b11;

  state_e             state_q;
  logic [NO_LEDS-1:0] pat_q;
  logic [NO_LEDS-1:0] pat_prev;
  logic [IDX_W-1:0]   index_q;
  logic               valid_q;
  logic               dir_q;
  logic               dir_known_q;
  logic               step_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;
  logic [1:0]         code_q;

  // Pattern decode
  logic             ev;
  logic             one_hot;
  logic [IDX_W-1:0] new_idx;
  logic             up;
  logic             adjacent;

  // Event classification
  logic             acquire;
  logic             bad;
  logic             jump;
  logic             mid_rev;
  logic             legal;
  logic             bounce;
  logic             err_set;
  logic [1:0]       err_new;

  always_comb begin
    ev      = (pat_q != pat_prev);
    one_hot = (pat_q != '0) && ((pat_q & (pat_q - NO_LEDS'(1))) == '0);
    new_idx = '0;
    for (int i = 0; i < NO_LEDS; i++) begin
      if (pat_q[i]) new_idx = IDX_W'(i);
    end
    up       = (new_idx > index_q);
    adjacent = up ? ((new_idx - index_q) == IDX_W'(1))
                  : ((index_q - new_idx) == IDX_W'(1));
  end

  always_comb begin
    acquire = 1'b0;
    bad     = 1'b0;
    jump    = 1'b0;
    mid_rev = 1'b0;
    legal   = 1'b0;
    bounce  = 1'b0;
    if (ev) begin
      if (state_q == IDLE) begin
        // An all-dark bank is a legal idle condition.
        if (one_hot)             acquire = 1'b1;
        else if (pat_q != '0)    bad     = 1'b1;
      end else begin
        if (!one_hot)            bad  = 1'b1;
        else if (!adjacent)      jump = 1'b1;
        else if (dir_known_q && (up != dir_q)) begin
          // A reversal is only legal from the end LED it was heading toward.
          if ((dir_q && (index_q == IDX_MAX)) || (!dir_q && (index_q == '0))) begin
            legal  = 1'b1;
            bounce = 1'b1;
          end else begin
            mid_rev = 1'b1;
          end
        end else begin
          legal = 1'b1;
        end
      end
    end
    err_set = bad | jump | mid_rev;
    err_new = bad ? ERR_BAD : (jump ? ERR_JUMP : (mid_rev ? ERR_REV : 2'b00));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      pat_prev    <= '0;
      index_q     <= '0;
      valid_q     <= 1'b0;
      dir_q       <= 1'b1;
      dir_known_q <= 1'b0;
      step_q      <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      code_q      <= 2'b00;
    end else begin
      pat_q    <= led_array_i;
      // Holding pat_q unconditionally is equivalent to "last differing
      // pattern": when pat_q did not change, pat_prev already equals it.
      pat_prev <= pat_q;
      step_q   <= legal;

      case (state_q)
        IDLE: begin
          if (acquire) begin
            state_q     <= TRACK;
            index_q     <= new_idx;
            valid_q     <= 1'b1;
            dir_known_q <= 1'b0;
          end
        end
        TRACK: begin
          if (bad) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end else begin
            // Index follows any one-hot pattern, even an illegal move, so
            // tracking resumes from where the LED actually is.
            if (legal || jump || mid_rev) index_q <= new_idx;
            if (legal || mid_rev)         dir_q   <= up;
            if (legal)                    dir_known_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      // New error outranks a coincident clear.
      if (err_set) begin
        err_q <= 1'b1;
        if (clr_i || !err_q) code_q <= err_new;
      end else if (clr_i) begin
        err_q  <= 1'b0;
        code_q <= 2'b00;
      end

      if (clr_i)                      cnt_q <= bounce ? CNT_W'(1) : '0;
      else if (bounce && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign index_o      = index_q;
  assign valid_o      = valid_q;
  assign dir_o        = dir_q;
  assign step_o       = step_q;
  assign bounce_cnt_o = cnt_q;
  assign err_o        = err_q;
  assign err_code_o   = code_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_led_snake_monitor.sv
module tb_led_snake_monitor;

  localparam int W = 17;  // {idx[2:0], valid, dir, step, cnt[7:0], err, code[1:0]}

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic [7:0] led_m, led_s;

  logic [2:0] m_idx, s_idx;
  logic       m_valid, m_dir, m_step, m_err, m_state;
  logic       s_valid, s_dir, s_step, s_err, s_state;
  logic [7:0] m_cnt;
  logic [1:0] s_cnt, m_code, s_code;

  logic [W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int step_cnt = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  led_snake_monitor #(.NO_LEDS(8), .CNT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .led_array_i(led_m), .clr_i(clr),
    .index_o(m_idx), .valid_o(m_valid), .dir_o(m_dir), .step_o(m_step),
    .bounce_cnt_o(m_cnt), .err_o(m_err), .err_code_o(m_code), .state_o(m_state)
  );

  led_snake_monitor #(.NO_LEDS(8), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .led_array_i(led_s), .clr_i(clr),
    .index_o(s_idx), .valid_o(s_valid), .dir_o(s_dir), .step_o(s_step),
    .bounce_cnt_o(s_cnt), .err_o(s_err), .err_code_o(s_code), .state_o(s_state)
  );

  always @(negedge clk) if (m_step) step_cnt++;

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] pk(int idx, bit v, bit d, bit s, int c,
                                      bit e, int code);
    return {3'(idx), v, d, s, 8'(c), e, 2'(code)};
  endfunction

  function automatic logic [W-1:0] obs(bit sat);
    if (sat) return {s_idx, s_valid, s_dir, s_step, 6'b0, s_cnt, s_err, s_code};
    return {m_idx, m_valid, m_dir, m_step, m_cnt, m_err, m_code};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input bit sat);
    logic [W-1:0] e;
    logic [W-1:0] o;
    e = exp_q.pop_front();
    o = obs(sat);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive one pattern, optionally with clr_i at the edge that processes it,
  // check outputs two edges later, then check step_o drops one cycle after.
  task automatic apply(input logic [7:0] p, input bit sat, input bit with_clr,
                       input logic [W-1:0] e, input string tag);
    logic st;
    @(negedge clk);
    if (sat) led_s = p; else led_m = p;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    clr = with_clr;
    @(posedge clk);
    #1 check(tag, sat);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    #1;
    st = sat ? s_step : m_step;
    tests++;
    assert (st === 1'b0) else begin
      fails++;
      $error("FAIL %s_step_low observed=%b expected=0", tag, st);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    led_m = 8'h00;
    led_s = 8'h00;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nb;
    int idx;
    bit d;
    rst_n = 1'b0;
    clr   = 1'b0;
    led_m = 8'h00;
    led_s = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-operation and re-acquisition
    apply(8'h10, 0, 0, pk(4, 1, 1, 0, 0, 0, 0), "pre_reset_acq");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 exp_q.push_back(pk(0, 0, 1, 0, 0, 0, 0));
    check("reset_async", 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 exp_q.push_back(pk(4, 1, 1, 0, 0, 0, 0));
    check("reset_reacq", 0);

    // Full sweep 0..7..0,1
    do_reset();
    @(posedge clk);
    #1 step_cnt = 0;
    apply(8'h01, 0, 0, pk(0, 1, 1, 0, 0, 0, 0), "sweep_acq");
    for (int i = 1; i <= 7; i++)
      apply(8'(1 << i), 0, 0, pk(i, 1, 1, 1, 0, 0, 0), "sweep_up");
    for (int i = 6; i >= 0; i--)
      apply(8'(1 << i), 0, 0, pk(i, 1, 0, 1, 1, 0, 0), "sweep_down");
    apply(8'h02, 0, 0, pk(1, 1, 1, 1, 2, 0, 0), "sweep_bounce0");
    tests++;
    assert (step_cnt == 15) else begin
      fails++;
      $error("FAIL sweep_step_count observed=%0d expected=15", step_cnt);
    end

    // Jump
    apply(8'h04, 0, 0, pk(2, 1, 1, 1, 2, 0, 0), "jump_pre");
    apply(8'h10, 0, 0, pk(4, 1, 1, 0, 2, 1, 2), "jump");

    // Multi-bit pattern while idle
    do_reset();
    apply(8'h18, 0, 0, pk(0, 0, 1, 0, 0, 1, 1), "idle_multi");

    // Mid-bar reversal
    do_reset();
    apply(8'h08, 0, 0, pk(3, 1, 1, 0, 0, 0, 0), "rev_acq");
    apply(8'h10, 0, 0, pk(4, 1, 1, 1, 0, 0, 0), "rev_up");
    apply(8'h08, 0, 0, pk(3, 1, 0, 0, 0, 1, 3), "rev_mid");
    apply(8'h04, 0, 0, pk(2, 1, 0, 1, 0, 1, 3), "rev_after");

    // Bad pattern, resync, clear, loss of light
    do_reset();
    apply(8'h20, 0, 0, pk(5, 1, 1, 0, 0, 0, 0), "bad_acq");
    apply(8'h18, 0, 0, pk(5, 0, 1, 0, 0, 1, 1), "bad_multi");
    apply(8'h80, 0, 0, pk(7, 1, 1, 0, 0, 1, 1), "bad_resync");
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 exp_q.push_back(pk(7, 1, 1, 0, 0, 0, 0));
    check("clr_pulse", 0);
    @(negedge clk);
    clr = 1'b0;
    apply(8'h00, 0, 0, pk(7, 0, 1, 0, 0, 1, 1), "track_dark");

    // Saturation with CNT_W=2: six legs = five bounces
    do_reset();
    apply(8'h01, 1, 0, pk(0, 1, 1, 0, 0, 0, 0), "sat_acq");
    nb = 0;
    for (int leg = 0; leg < 6; leg++) begin
      for (int k = 1; k <= 7; k++) begin
        d   = (leg % 2 == 0);
        idx = d ? k : 7 - k;
        if (leg > 0 && k == 1) nb++;
        apply(8'(1 << idx), 1, 0, pk(idx, 1, d, 1, (nb > 3) ? 3 : nb, 0, 0), "sat_leg");
      end
    end

    // Clear coinciding with a jump, then with a legal bounce
    apply(8'h04, 1, 1, pk(2, 1, 0, 0, 0, 1, 2), "clr_vs_jump");
    apply(8'h02, 1, 0, pk(1, 1, 0, 1, 0, 1, 2), "sat_down1");
    apply(8'h01, 1, 0, pk(0, 1, 0, 1, 0, 1, 2), "sat_down0");
    apply(8'h02, 1, 1, pk(1, 1, 1, 1, 1, 0, 0), "clr_vs_bounce");

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
